// File: rtl/pipe_stage_elastic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic_pkg
// Description : Shared constants for the elastic pipeline stages of the MIPS
//               5-stage CPU: default depth, stage bundle field layout and a
//               pointer-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_elastic_pkg;

    // Default number of skid entries per stage
    localparam int c_PIPE_DEPTH_DEFAULT = 2;

    // IF/ID bundle: {instr, pc}
    localparam int c_IFID_PC_LSB     = 0;
    localparam int c_IFID_PC_W       = 32;
    localparam int c_IFID_INSTR_LSB  = 32;
    localparam int c_IFID_INSTR_W    = 32;

    // ID/EXE bundle: {ctrl, rd, imm, rt_val, rs_val}
    localparam int c_IDEX_RS_LSB     = 0;
    localparam int c_IDEX_RT_LSB     = 32;
    localparam int c_IDEX_IMM_LSB    = 64;
    localparam int c_IDEX_RD_LSB     = 96;
    localparam int c_IDEX_RD_W       = 5;
    localparam int c_IDEX_CTRL_LSB   = 101;
    localparam int c_IDEX_CTRL_W     = 12;

    // EXE/MEM bundle: {ctrl, rd, store_val, alu_res}
    localparam int c_EXMEM_ALU_LSB   = 0;
    localparam int c_EXMEM_STV_LSB   = 32;
    localparam int c_EXMEM_RD_LSB    = 64;
    localparam int c_EXMEM_CTRL_LSB  = 69;
    localparam int c_EXMEM_CTRL_W    = 6;

    // MEM/WB bundle: {ctrl, rd, wb_val}
    localparam int c_MEMWB_VAL_LSB   = 0;
    localparam int c_MEMWB_RD_LSB    = 32;
    localparam int c_MEMWB_CTRL_LSB  = 37;
    localparam int c_MEMWB_CTRL_W    = 2;

    // Pointer width that stays at least one bit for a single-entry stage
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : pipe_stage_elastic_pkg
`default_nettype wire

// File: rtl/pipe_stage_elastic_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority; increment stops once the counter reaches all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Elastic valid/ready pipeline stage with a DEPTH-entry circular
//               skid buffer, synchronous flush and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = c_PIPE_DEPTH_DEFAULT,
    parameter bit REG_READY = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_clr
);

    localparam int c_PTR_W = ptr_width(DEPTH);
    localparam int c_CW    = $clog2(DEPTH+1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH-1);
    localparam logic [c_CW-1:0]    c_FULL = c_CW'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CW-1:0]    r_count;

    logic w_push;
    logic w_pop;
    logic w_in_ready;
    logic w_out_valid;
    logic w_stall_inc;

    // Ready depends only on occupancy unless the pass-through mode is chosen;
    // held low during reset and flush so no bundle is taken then
    assign w_in_ready  = rst_n & ~flush &
                         ((r_count != c_FULL) | ((REG_READY == 1'b0) & out_ready));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_stall_inc = w_out_valid & ~out_ready & ~flush;

    // Storage write on accepted push; a full-stage push under REG_READY=0
    // overwrites the slot that is being popped in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy tracking; flush rewinds everything to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_inc),
        .i_clr (stall_clr),
        .o_cnt (stall_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : pipe_stage_elastic
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_elastic
// Description : Directed bench for three stage configurations with a data
//               scoreboard per instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: DEPTH=2, REG_READY=1, CNT_W=4
    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_count;
    logic [3:0] a_stall;
    // Instance B: DEPTH=3, REG_READY=1, CNT_W=16
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;
    logic [15:0] b_stall;
    // Instance C: DEPTH=1, REG_READY=0, CNT_W=16
    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_stall_clr;
    logic [7:0]  c_in_data, c_out_data;
    logic [0:0]  c_count;
    logic [15:0] c_stall;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    pipe_stage_elastic #(.DATA_W(8), .DEPTH(2), .REG_READY(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count),
        .stall_cnt(a_stall), .stall_clr(a_stall_clr));

    pipe_stage_elastic #(.DATA_W(8), .DEPTH(3), .REG_READY(1'b1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count),
        .stall_cnt(b_stall), .stall_clr(b_stall_clr));

    pipe_stage_elastic #(.DATA_W(8), .DEPTH(1), .REG_READY(1'b0), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count),
        .stall_cnt(c_stall), .stall_clr(c_stall_clr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare a popped word against the scoreboard head
    task automatic sb_pop(input string tag, inout logic [7:0] q[$], input logic [7:0] obs);
        n_chk++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed pop of %0h expected no output", tag, obs);
        end
        if (q.size() != 0) chk(tag, 32'(obs), 32'(q.pop_front()));
    endtask

    // One clock: scoreboard sampling at the falling edge, then rising edge + 1
    task automatic tick();
        @(negedge clk);
        if (a_out_valid && a_out_ready) sb_pop("a_data", qa, a_out_data);
        if (b_out_valid && b_out_ready) sb_pop("b_data", qb, b_out_data);
        if (c_out_valid && c_out_ready) sb_pop("c_data", qc, c_out_data);
        if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        if (c_in_valid && c_in_ready) qc.push_back(c_in_data);
        if (a_flush) qa.delete();
        if (b_flush) qb.delete();
        if (c_flush) qc.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0;
        {a_flush, a_in_valid, a_out_ready, a_stall_clr} = '0; a_in_data = '0;
        {b_flush, b_in_valid, b_out_ready, b_stall_clr} = '0; b_in_data = '0;
        {c_flush, c_in_valid, c_out_ready, c_stall_clr} = '0; c_in_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_count",     32'(a_count),     0);
        chk("rst_in_ready",  32'(a_in_ready),  0);
        chk("rst_stall",     32'(a_stall),     0);
        chk("rst_out_data",  32'(a_out_data),  0);
        rst_n = 1'b1;
        #1;
        chk("a_ready_after_rst", 32'(a_in_ready), 1);

        // Streaming through A with out_ready high
        a_out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(i * 8'h11);
            tick();
            chk("stream_valid", 32'(a_out_valid), 1);
            chk("stream_data",  32'(a_out_data),  32'(i * 8'h11));
            chk("stream_count", 32'(a_count),     1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_drain_count", 32'(a_count), 0);

        // Flush of a full A stage with a concurrent push attempt
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = 8'h01; tick();
        a_in_data   = 8'h02; tick();
        chk("flush_pre_count", 32'(a_count),    2);
        chk("flush_pre_ready", 32'(a_in_ready), 0);
        a_flush = 1'b1; a_in_data = 8'h77; a_out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 32'(a_in_ready), 0);
        a_out_ready = 1'b0;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flush_count", 32'(a_count),     0);
        chk("flush_valid", 32'(a_out_valid), 0);
        chk("flush_stall_kept", 32'(a_stall), 1);
        a_out_ready = 1'b1;
        repeat (2) tick();
        chk("flush_no_emit", 32'(a_out_valid), 0);

        // Backpressure and pointer wrap on B
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_data = 8'hA0 + 8'(i);
            #1;
            chk("bp_in_ready", 32'(b_in_ready), (i < 3) ? 1 : 0);
            tick();
            chk("bp_count", 32'(b_count), (i < 3) ? i + 1 : 3);
        end
        chk("bp_stall", 32'(b_stall), 3);
        b_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            acc = b_in_valid & b_in_ready;
            tick();
            if (acc) b_in_data = b_in_data + 8'h01;
        end
        b_in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 32'(b_count), 0);
        chk("bp_stall_hold", 32'(b_stall), 3);

        // Single-entry pass-through register behaviour on C
        c_in_valid = 1'b1; c_in_data = 8'h44;
        tick();
        chk("c_full_count", 32'(c_count),    1);
        chk("c_full_ready", 32'(c_in_ready), 0);
        c_out_ready = 1'b1; c_in_data = 8'h55;
        #1;
        chk("c_pass_ready", 32'(c_in_ready), 1);
        tick();
        chk("c_pass_count", 32'(c_count),    1);
        chk("c_pass_data",  32'(c_out_data), 8'h55);
        c_in_valid = 1'b0;
        tick();
        chk("c_drain_count", 32'(c_count), 0);

        // Stall counter saturation and clear on A (CNT_W=4)
        a_stall_clr = 1'b1; tick(); a_stall_clr = 1'b0;
        chk("sat_clr0", 32'(a_stall), 0);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h99;
        tick();
        a_in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_max", 32'(a_stall), 15);
        chk("sat_data_held", 32'(a_out_data), 8'h99);
        a_stall_clr = 1'b1; tick(); a_stall_clr = 1'b0;
        chk("sat_clr", 32'(a_stall), 0);
        tick();
        chk("sat_restart", 32'(a_stall), 1);
        a_out_ready = 1'b1; tick();
        chk("sat_drain", 32'(a_count), 0);

        // Asynchronous reset in the middle of a cycle with entries held
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 8'h5A; tick();
        a_in_data = 8'h5B; tick();
        a_in_valid = 1'b0;
        chk("mid_pre_count", 32'(a_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(a_out_valid), 0);
        chk("mid_count",     32'(a_count),     0);
        chk("mid_out_data",  32'(a_out_data),  0);
        chk("mid_stall",     32'(a_stall),     0);
        chk("mid_in_ready",  32'(a_in_ready),  0);
        qa.delete(); qb.delete(); qc.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (2) tick();
        chk("post_rst_valid", 32'(a_out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_elastic
`default_nettype wire
